// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencers: strobe bit positions,
// per-state strobe encodings, default phase lengths and the sequencer state type.
package rtc_bus_pkg;

    localparam int unsigned CtrlCs = 3;
    localparam int unsigned CtrlAd = 2;
    localparam int unsigned CtrlRd = 1;
    localparam int unsigned CtrlWr = 0;

    // Active-low strobes, ordered {CS, AD, RD, WR}
    localparam logic [3:0] CtrlIdle  = 4'b1111;
    localparam logic [3:0] CtrlAsu   = 4'b1011;
    localparam logic [3:0] CtrlAddr  = 4'b0010;
    localparam logic [3:0] CtrlAhld  = 4'b1011;
    localparam logic [3:0] CtrlTurn  = 4'b1111;
    localparam logic [3:0] CtrlRdStb = 4'b0101;
    localparam logic [3:0] CtrlRec   = 4'b1111;

    localparam int unsigned DefTAsu  = 2;
    localparam int unsigned DefTAddr = 6;
    localparam int unsigned DefTAhld = 2;
    localparam int unsigned DefTTurn = 12;
    localparam int unsigned DefTRd   = 6;
    localparam int unsigned DefTRec  = 9;

    localparam int unsigned PhaseCntW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAsu,
        StAddr,
        StAhld,
        StTurn,
        StRd,
        StRec
    } rtc_state_e;

    function automatic logic [3:0] ctrl_of_state(rtc_state_e st);
        logic [3:0] c;
        c = CtrlIdle;
        unique case (st)
            StIdle:  c = CtrlIdle;
            StAsu:   c = CtrlAsu;
            StAddr:  c = CtrlAddr;
            StAhld:  c = CtrlAhld;
            StTurn:  c = CtrlTurn;
            StRd:    c = CtrlRdStb;
            StRec:   c = CtrlRec;
            default: c = CtrlIdle;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module rtc_phase_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             tc
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/rtc_read_seq.sv
// Burst read sequencer for an RTC on a multiplexed address/data bus: address phase,
// turnaround, read strobe and recovery per register, with auto-incrementing address.
module rtc_read_seq
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_ASU  = DefTAsu,
    parameter int unsigned T_ADDR = DefTAddr,
    parameter int unsigned T_AHLD = DefTAhld,
    parameter int unsigned T_TURN = DefTTurn,
    parameter int unsigned T_RD   = DefTRd,
    parameter int unsigned T_REC  = DefTRec
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] base_addr,
    input  logic [2:0] num_regs,
    input  logic [7:0] bus_in,
    output logic [3:0] control,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic [7:0] data_out,
    output logic [7:0] data_addr,
    output logic       data_valid,
    output logic       busy,
    output logic       done
);

    rtc_state_e state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [2:0] remain_q, remain_d;
    logic [3:0] control_q;
    logic       bus_oe_q, busy_q, done_q, done_d;
    logic [7:0] data_out_q, data_addr_q;
    logic       data_valid_q, capture;
    logic       load, tc;
    logic [PhaseCntW-1:0] load_val;

    // Counter is loaded with length-1 so tc marks the last cycle of a phase
    function automatic logic [PhaseCntW-1:0] phase_len(rtc_state_e st);
        logic [PhaseCntW-1:0] n;
        n = '0;
        unique case (st)
            StAsu:   n = PhaseCntW'(T_ASU - 1);
            StAddr:  n = PhaseCntW'(T_ADDR - 1);
            StAhld:  n = PhaseCntW'(T_AHLD - 1);
            StTurn:  n = PhaseCntW'(T_TURN - 1);
            StRd:    n = PhaseCntW'(T_RD - 1);
            StRec:   n = PhaseCntW'(T_REC - 1);
            default: n = '0;
        endcase
        return n;
    endfunction

    rtc_phase_timer #(
        .Width(PhaseCntW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .load_val(load_val),
        .tc      (tc)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_regs != 3'd0) begin
                        state_d  = StAsu;
                        addr_d   = base_addr;
                        remain_d = num_regs;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StAsu:  if (tc) state_d = StAddr;
            StAddr: if (tc) state_d = StAhld;
            StAhld: if (tc) state_d = StTurn;
            StTurn: if (tc) state_d = StRd;
            StRd:   if (tc) state_d = StRec;
            StRec: begin
                if (tc) begin
                    if (remain_q > 3'd1) begin
                        state_d  = StAsu;
                        addr_d   = addr_q + 8'd1;
                        remain_d = remain_q - 3'd1;
                    end else begin
                        state_d  = StIdle;
                        remain_d = 3'd0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        load     = (state_d != state_q);
        load_val = phase_len(state_d);
        capture  = (state_q == StRd) && tc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remain_q     <= '0;
            control_q    <= CtrlIdle;
            bus_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
            data_addr_q  <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            control_q    <= ctrl_of_state(state_d);
            bus_oe_q     <= (state_d == StAsu) || (state_d == StAddr) || (state_d == StAhld);
            busy_q       <= (state_d != StIdle);
            done_q       <= done_d;
            data_valid_q <= capture;
            if (capture) begin
                data_out_q  <= bus_in;
                data_addr_q <= addr_q;
            end
        end
    end

    assign control    = control_q;
    assign bus_out    = addr_q;
    assign bus_oe     = bus_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_out_q;
    assign data_addr  = data_addr_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_rtc_read_seq.sv
// Randomized bench for rtc_read_seq: each burst is checked cycle by cycle against a
// schedule computed from the per-register phase lengths.
module tb_rtc_read_seq;
    import rtc_bus_pkg::*;

    localparam int Per = 2 + 6 + 2 + 12 + 6 + 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [2:0] num_regs;
    logic [7:0] bus_in;
    logic [3:0] control;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] data_out;
    logic [7:0] data_addr;
    logic       data_valid;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_dout  = 8'h00;
    logic [7:0] exp_daddr = 8'h00;

    rtc_read_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_regs  (num_regs),
        .bus_in    (bus_in),
        .control   (control),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .data_out  (data_out),
        .data_addr (data_addr),
        .data_valid(data_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Strobe pattern for position p (0..Per-1) within one register's period
    function automatic logic [3:0] exp_ctrl(input int p);
        if (p < 2)       return 4'b1011;
        else if (p < 8)  return 4'b0010;
        else if (p < 10) return 4'b1011;
        else if (p < 22) return 4'b1111;
        else if (p < 28) return 4'b0101;
        else             return 4'b1111;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check_eq("oe_cs_rd", {31'd0, bus_oe & ~control[CtrlCs] & ~control[CtrlRd]}, 32'd0);
            if (!control[CtrlWr]) check_eq("wr_addr_only", {31'd0, bus_oe}, 32'd1);
        end
    end

    task automatic check_idle(input bit exp_done);
        check_eq("ctrl_idle", {28'd0, control}, {28'd0, CtrlIdle});
        check_eq("busy_idle", {31'd0, busy}, 32'd0);
        check_eq("oe_idle", {31'd0, bus_oe}, 32'd0);
        check_eq("dv_idle", {31'd0, data_valid}, 32'd0);
        check_eq("done_idle", {31'd0, done}, {31'd0, exp_done});
        check_eq("dout_hold", {24'd0, data_out}, {24'd0, exp_dout});
        check_eq("daddr_hold", {24'd0, data_addr}, {24'd0, exp_daddr});
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            start  = 1'b0;
            bus_in = 8'($urandom);
            @(negedge clk);
            check_idle(1'b0);
        end
    endtask

    task automatic run_burst(input logic [7:0] base, input logic [2:0] n, input bit pre,
                             input bit poke, input bit chain, input logic [7:0] cbase,
                             input logic [2:0] cn, input int abort_at);
        int total;
        logic [7:0] cap;
        logic [7:0] a;
        total = Per * int'(n) + 1;
        cap = 8'h00;
        if (!pre) begin
            @(posedge clk);
            #1;
            start     = 1'b1;
            base_addr = base;
            num_regs  = n;
            bus_in    = 8'($urandom);
        end
        for (int j = 1; j <= total; j++) begin
            int r, p;
            r = (j - 1) / Per;
            p = (j - 1) % Per;
            a = base + 8'(r);
            @(posedge clk);
            #1;
            bus_in    = 8'($urandom);
            base_addr = 8'($urandom);
            num_regs  = 3'($urandom);
            if (j < total) begin
                start = (poke && j == 10) || ($urandom_range(0, 5) == 0);
            end else begin
                start = chain;
                if (chain) begin
                    base_addr = cbase;
                    num_regs  = cn;
                end
            end
            if (j < total && p == 27) cap = bus_in;
            @(negedge clk);
            if (j < total) begin
                check_eq("ctrl", {28'd0, control}, {28'd0, exp_ctrl(p)});
                check_eq("busy", {31'd0, busy}, 32'd1);
                check_eq("done_busy", {31'd0, done}, 32'd0);
                check_eq("oe", {31'd0, bus_oe}, {31'd0, p < 10});
                if (p < 10) check_eq("bus_out", {24'd0, bus_out}, {24'd0, a});
                check_eq("dv", {31'd0, data_valid}, {31'd0, p == 28});
                if (p == 28) begin
                    exp_dout  = cap;
                    exp_daddr = a;
                end
                check_eq("dout", {24'd0, data_out}, {24'd0, exp_dout});
                check_eq("daddr", {24'd0, data_addr}, {24'd0, exp_daddr});
            end else begin
                check_idle(1'b1);
            end
            if (j == abort_at) begin
                #2;
                reset = 1'b1;
                #1;
                exp_dout  = 8'h00;
                exp_daddr = 8'h00;
                check_eq("rst_ctrl", {28'd0, control}, {28'd0, CtrlIdle});
                check_eq("rst_oe", {31'd0, bus_oe}, 32'd0);
                check_eq("rst_bus_out", {24'd0, bus_out}, 32'd0);
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_dout", {24'd0, data_out}, 32'd0);
                start = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                idle_cycles(Per * 4);
                return;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 8'h00;
        num_regs  = 3'd0;
        bus_in    = 8'h00;
        #3;
        check_eq("por_ctrl", {28'd0, control}, {28'd0, CtrlIdle});
        check_eq("por_oe", {31'd0, bus_oe}, 32'd0);
        check_eq("por_bus_out", {24'd0, bus_out}, 32'd0);
        check_eq("por_dout", {24'd0, data_out}, 32'd0);
        check_eq("por_daddr", {24'd0, data_addr}, 32'd0);
        check_eq("por_dv", {31'd0, data_valid}, 32'd0);
        check_eq("por_busy", {31'd0, busy}, 32'd0);
        check_eq("por_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(3);

        run_burst(8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 0);
        idle_cycles(2);
        run_burst(8'hFE, 3'd3, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 0);
        idle_cycles(2);
        run_burst(8'h55, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 0);
        idle_cycles(2);
        run_burst(8'h10, 3'd2, 1'b0, 1'b1, 1'b1, 8'h80, 3'd1, 0);
        run_burst(8'h80, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 0);
        idle_cycles(2);
        // Abort in the RD phase of the second of four registers
        run_burst(8'h30, 3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1 + Per + 24);
        run_burst(8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 0);
        idle_cycles(1);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            logic [2:0] n;
            b = 8'($urandom);
            n = 3'($urandom_range(0, 7));
            run_burst(b, n, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 0);
            idle_cycles(int'($urandom_range(0, 3)) + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_read_seq.md
RTC_READ_SEQ -- requirements
Module: rtc_read_seq

Interface
REQ-001 Parameter T_ASU, default 2, address setup cycles (CS high, AD low).
REQ-002 Parameter T_ADDR, default 6, address strobe cycles.
REQ-003 Parameter T_AHLD, default 2, address hold cycles.
REQ-004 Parameter T_TURN, default 12, bus turnaround cycles.
REQ-005 Parameter T_RD, default 6, read strobe cycles.
REQ-006 Parameter T_REC, default 9, recovery cycles.
REQ-007 clk  input  1  sole clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  burst request, sampled in IDLE only.
REQ-010 base_addr  input  8  first RTC register address of burst.
REQ-011 num_regs  input  3  registers to read, 0..7.
REQ-012 bus_in  input  8  RTC multiplexed AD bus, read value.
REQ-013 control  output  4  active-low strobes: [3]=CS, [2]=AD, [1]=RD, [0]=WR.
REQ-014 bus_out  output  8  address driven onto AD bus.
REQ-015 bus_oe  output  1  1 = block drives AD bus with bus_out.
REQ-016 data_out  output  8  last register value read.
REQ-017 data_addr  output  8  address belonging to data_out.
REQ-018 data_valid  output  1  one-cycle strobe qualifying data_out/data_addr.
REQ-019 busy  output  1  burst in progress.
REQ-020 done  output  1  one-cycle strobe, burst complete.

Function
REQ-021 States: IDLE, ASU, ADDR, AHLD, TURN, RD, REC; each non-IDLE state lasts exactly its T_* cycles, timed by one phase down-counter.
REQ-022 Registered control per state: IDLE 1111, ASU 1011, ADDR 0010, AHLD 1011, TURN 1111, RD 0101, REC 1111.
REQ-023 bus_oe = 1 in ASU, ADDR, AHLD only; bus_out = current address, held stable throughout all three.
REQ-024 IDLE with start=1 and num_regs!=0: latch base_addr and num_regs, enter ASU next cycle (cycle 1 relative to start at cycle 0), busy=1 from cycle 1.
REQ-025 IDLE with start=1 and num_regs=0: no bus activity, done=1 in cycle 1, busy stays 0.
REQ-026 Transitions: ASU->ADDR->AHLD->TURN->RD->REC; REC end -> ASU if registers remain, else IDLE.
REQ-027 bus_in sampled on the last RD cycle; data_out, data_addr updated and data_valid=1 in the following cycle (first REC cycle).
REQ-028 Per-register period = sum of T_* (37 cycles by default); burst of N registers: done=1 and busy=0 in cycle 37*N+1.
REQ-029 Address increments by 1 per register, 8-bit modulo wrap (0xFF -> 0x00).
REQ-030 start ignored while busy; start in the done cycle (state IDLE) is accepted.
REQ-031 CS and RD never low while bus_oe=1; WR never low outside ADDR.
REQ-032 data_out and data_addr hold their values between data_valid strobes.

Reset
REQ-033 Reset asserted: state IDLE, control=1111, bus_oe=0, bus_out=0, data_out=0, data_addr=0, data_valid=0, busy=0, done=0, counter and latched burst cleared, all immediately and asynchronously.
REQ-034 Reset mid-burst abandons the burst with no done strobe; after release, the block waits in IDLE for a new start.

Structure
REQ-035 Shared package rtc_bus_pkg holds the control bit indices, per-state control encodings, default T_* values and state enumeration, shared with the write sequencer.
REQ-036 One sub-module, rtc_phase_timer: loadable down-counter with a terminal-count flag.

Verification
REQ-037 start, base_addr=0x00, num_regs=1, bus_in=0x59 during RD -> control sequence exactly as in REQ-022 with default lengths; data_valid cycle 29 with data_out=0x59, data_addr=0x00; done cycle 38.
REQ-038 base_addr=0xFE, num_regs=3 -> bus_out 0xFE, 0xFF, 0x00 in successive ASU phases; three data_valid strobes 37 cycles apart; done cycle 112.
REQ-039 num_regs=0 -> control stays 1111, bus_oe=0, done=1 in cycle 1 only.
REQ-040 start pulsed again at cycle 10 of an active burst -> ignored; start in the done cycle -> new burst ASU begins next cycle.
REQ-041 reset asserted during RD of register 2 of 4 -> control=1111, bus_oe=0 without waiting for a clock edge; no done strobe; next start yields a normal burst.
REQ-042 Assertion bench-wide: bus_oe=1 never coincides with control[3]=0 together with control[1]=0.
